// File: rtl/v_store_wr_streamer.sv
// Vector store write streamer: buffers store-data beats in a FIFO and feeds the
// AXI master controller's write command/stream interface, reporting completion.
module v_store_wr_streamer #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  cmd_size,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] din_data,
  output logic                          cmd_done,
  output logic                          busy,
  output logic                          ctrl_wstart,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_waddr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_wxfer_size,
  output logic                          wr_tvalid,
  input  logic                          wr_tready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] wr_tdata,
  input  logic                          ctrl_wdone
);

  localparam int unsigned AW   = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW   = C_M_AXI_DATA_WIDTH;
  localparam int unsigned XW   = C_XFER_SIZE_WIDTH;
  localparam int unsigned BPB  = DW / 8;
  localparam int unsigned SH   = $clog2(BPB);
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PTRW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_DONE} state_t;

  state_t           state;
  logic [DW-1:0]    mem [FIFO_DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic [XW-1:0]    beats_left;
  logic [XW-1:0]    cmd_beats;
  logic             wdone_seen;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             accept;
  logic             last_pop;

  // Wrap-bit pointer compare distinguishes full from empty
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign din_ready  = !fifo_full && !rst;
  assign push       = din_valid && din_ready;

  // First-word fall-through: head of FIFO drives the stream directly
  assign wr_tdata   = mem[rd_ptr[PW-1:0]];
  assign wr_tvalid  = (state == STREAM) && !fifo_empty && (beats_left != '0) && !rst;
  assign pop        = wr_tvalid && wr_tready;
  assign last_pop   = pop && (beats_left == XW'(1));

  assign accept     = cmd_valid && cmd_ready && (state == IDLE);
  assign cmd_beats  = cmd_size >> SH;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= din_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
    end
  end

  // Command sequencing; pulses default low every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cmd_ready         <= 1'b0;
      cmd_done          <= 1'b0;
      busy              <= 1'b0;
      ctrl_wstart       <= 1'b0;
      ctrl_waddr_offset <= '0;
      ctrl_wxfer_size   <= '0;
      beats_left        <= '0;
      wdone_seen        <= 1'b0;
    end else begin
      ctrl_wstart <= 1'b0;
      cmd_done    <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready  <= 1'b1;
          wdone_seen <= 1'b0;
          if (accept) begin
            ctrl_waddr_offset <= cmd_addr;
            ctrl_wxfer_size   <= cmd_size;
            beats_left        <= cmd_beats;
            if (cmd_beats == '0) begin
              cmd_done <= 1'b1;
            end else begin
              state       <= START;
              cmd_ready   <= 1'b0;
              busy        <= 1'b1;
              ctrl_wstart <= 1'b1;
            end
          end
        end
        START: begin
          state <= STREAM;
          if (ctrl_wdone) wdone_seen <= 1'b1;
        end
        STREAM: begin
          if (ctrl_wdone) wdone_seen <= 1'b1;
          if (pop) beats_left <= beats_left - XW'(1);
          // Controller may report done before the last beat leaves
          if (last_pop) begin
            if (wdone_seen || ctrl_wdone) begin
              state      <= IDLE;
              cmd_done   <= 1'b1;
              cmd_ready  <= 1'b1;
              busy       <= 1'b0;
              wdone_seen <= 1'b0;
            end else begin
              state <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          if (ctrl_wdone) begin
            state      <= IDLE;
            cmd_done   <= 1'b1;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            wdone_seen <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v_store_wr_streamer.sv
// Bench for v_store_wr_streamer: directed and random store commands checked
// against a transaction-level model of beat order, handshakes and completion.
module tb_v_store_wr_streamer;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned XW    = 32;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [XW-1:0] cmd_size = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [DW-1:0] din_data = '0;
  logic          cmd_done;
  logic          busy;
  logic          ctrl_wstart;
  logic [AW-1:0] ctrl_waddr_offset;
  logic [XW-1:0] ctrl_wxfer_size;
  logic          wr_tvalid;
  logic          wr_tready = 1'b0;
  logic [DW-1:0] wr_tdata;
  logic          ctrl_wdone = 1'b0;

  v_store_wr_streamer #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
    .C_XFER_SIZE_WIDTH(XW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .cmd_done(cmd_done), .busy(busy), .ctrl_wstart(ctrl_wstart),
    .ctrl_waddr_offset(ctrl_waddr_offset), .ctrl_wxfer_size(ctrl_wxfer_size),
    .wr_tvalid(wr_tvalid), .wr_tready(wr_tready), .wr_tdata(wr_tdata),
    .ctrl_wdone(ctrl_wdone)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: data queue, remaining beats, done bookkeeping
  logic [DW-1:0] q[$];
  int            m_rem = 0;
  bit            m_busy = 0, m_seen = 0, m_done_next = 0, m_wstart_next = 0;
  bit            m_rst_prev = 0, stall_prev = 0;
  logic [DW-1:0] stall_data = '0;
  logic [AW-1:0] m_addr = '0;
  logic [XW-1:0] m_size = '0;
  int            n_wstart = 0, n_done = 0;

  always @(negedge clk) begin
    bit exp_tv, exp_rdy, exp_din;
    int beats;
    if (rst) begin
      chk("rst din_ready", din_ready, 0);
      chk("rst wr_tvalid", wr_tvalid, 0);
      if (m_rst_prev) begin
        chk("rst cmd_ready", cmd_ready, 0);
        chk("rst cmd_done", cmd_done, 0);
        chk("rst busy", busy, 0);
        chk("rst ctrl_wstart", ctrl_wstart, 0);
        chk("rst waddr", ctrl_waddr_offset, 0);
        chk("rst wxfer", ctrl_wxfer_size, 0);
      end
      q.delete();
      m_busy = 0; m_rem = 0; m_seen = 0; m_done_next = 0; m_wstart_next = 0;
      stall_prev = 0; m_rst_prev = 1;
    end else begin
      exp_tv  = m_busy && !m_wstart_next && (m_rem > 0) && (q.size() > 0);
      exp_rdy = !m_busy && !m_rst_prev;
      exp_din = q.size() < DEPTH;
      chk("cmd_done", cmd_done, m_done_next);
      chk("ctrl_wstart", ctrl_wstart, m_wstart_next);
      chk("busy", busy, m_busy);
      chk("cmd_ready", cmd_ready, exp_rdy);
      chk("din_ready", din_ready, exp_din);
      chk("wr_tvalid", wr_tvalid, exp_tv);
      if (m_busy) begin
        chk("ctrl_waddr_offset", ctrl_waddr_offset, m_addr);
        chk("ctrl_wxfer_size", ctrl_wxfer_size, m_size);
      end
      if (stall_prev) chk("wr_tdata hold", wr_tdata, stall_data);
      if (cmd_done === 1'b1) n_done++;
      if (ctrl_wstart === 1'b1) n_wstart++;

      m_done_next = 0; m_wstart_next = 0;
      stall_prev = exp_tv && !wr_tready;
      stall_data = wr_tdata;
      if (exp_tv && wr_tready) begin
        chk("wr_tdata order", wr_tdata, q[0]);
        void'(q.pop_front());
        m_rem--;
      end
      if (m_busy && ctrl_wdone) m_seen = 1;
      if (m_busy && m_rem == 0 && m_seen) begin
        m_busy = 0;
        m_done_next = 1;
      end else if (exp_rdy && cmd_valid) begin
        beats  = int'(cmd_size / 4);
        m_addr = cmd_addr;
        m_size = cmd_size;
        if (beats == 0) begin
          m_done_next = 1;
        end else begin
          m_busy = 1; m_rem = beats; m_seen = 0; m_wstart_next = 1;
        end
      end
      if (din_valid && exp_din) q.push_back(din_data);
      m_rst_prev = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b1;
      din_data  = DW'(base + i);
      for (int t = 0; ; t++) begin
        bit acc;
        acc = din_ready;
        tick();
        if (acc) break;
        if (t > 2000) begin
          chk("push timeout din_ready", din_ready, 1);
          din_valid = 1'b0;
          return;
        end
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [XW-1:0] s);
    cmd_addr  = a;
    cmd_size  = s;
    cmd_valid = 1'b1;
    for (int t = 0; ; t++) begin
      bit acc;
      acc = cmd_ready;
      tick();
      if (acc) break;
      if (t > 2000) begin
        chk("cmd timeout cmd_ready", cmd_ready, 1);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic respond(input int dly);
    for (int t = 0; !m_busy; t++) begin
      if (t > 2000) begin chk("respond start timeout busy", busy, 1); return; end
      tick();
    end
    repeat (dly) tick();
    ctrl_wdone = 1'b1;
    tick();
    ctrl_wdone = 1'b0;
    for (int t = 0; m_busy; t++) begin
      if (t > 2000) begin chk("respond end timeout busy", busy, 0); return; end
      tick();
    end
  endtask

  task automatic same_cycle_done();
    for (int t = 0; !(m_busy && m_rem == 1 && wr_tvalid && wr_tready); t++) begin
      if (t > 2000) begin chk("last beat timeout wr_tvalid", wr_tvalid, 1); return; end
      tick();
    end
    ctrl_wdone = 1'b1;
    tick();
    ctrl_wdone = 1'b0;
  endtask

  int exp_ws = 0, exp_dn = 0;
  bit stop = 0;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("post-reset cmd_ready", cmd_ready, 1);
    chk("post-reset waddr", ctrl_waddr_offset, 0);

    // 16 preloaded beats, full-rate drain
    wr_tready = 1'b1;
    push_n(16, 0);
    chk("preload din_ready", din_ready, 0);
    send_cmd(AW'('h100), XW'(64));
    respond(20);
    exp_ws++; exp_dn++;
    repeat (2) tick();
    chk("s1 n_wstart", n_wstart, exp_ws);
    chk("s1 n_done", n_done, exp_dn);

    // zero-length command
    send_cmd(AW'('h40), XW'(0));
    exp_dn++;
    repeat (2) tick();
    chk("s2 n_wstart", n_wstart, exp_ws);
    chk("s2 n_done", n_done, exp_dn);

    // overfill with no command, then drain with random backpressure
    wr_tready = 1'b0;
    push_n(16, 'h1000);
    tick();
    chk("s3 full din_ready", din_ready, 0);
    stop = 0;
    fork
      push_n(4, 'h1010);
      begin send_cmd(AW'('h2000), XW'(80)); respond(30); stop = 1; end
      while (!stop) begin wr_tready = 1'($urandom_range(0, 1)); tick(); end
    join
    wr_tready = 1'b1;
    exp_ws++; exp_dn++;
    repeat (2) tick();
    chk("s3 n_done", n_done, exp_dn);

    // back-to-back commands sharing a continuous data stream
    fork
      push_n(5, 'h50);
      begin send_cmd(AW'('h500), XW'(8)); send_cmd(AW'('h600), XW'(12)); end
      begin respond(4); respond(4); end
    join
    exp_ws += 2; exp_dn += 2;
    repeat (2) tick();
    chk("s4 n_wstart", n_wstart, exp_ws);
    chk("s4 n_done", n_done, exp_dn);

    // controller done coincides with the final beat
    push_n(4, 'h70);
    send_cmd(AW'('h700), XW'(16));
    same_cycle_done();
    chk("s5 cmd_done", cmd_done, 1);
    exp_ws++; exp_dn++;
    repeat (2) tick();
    chk("s5 busy", busy, 0);
    chk("s5 n_done", n_done, exp_dn);

    // reset part way through a stream, then a fresh command
    push_n(8, 'h300);
    send_cmd(AW'('h300), XW'(32));
    for (int t = 0; m_rem != 5; t++) begin
      if (t > 2000) begin chk("s6 pop timeout wr_tvalid", wr_tvalid, 1); break; end
      tick();
    end
    exp_ws++;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("s6 wr_tvalid", wr_tvalid, 0);
    chk("s6 n_done", n_done, exp_dn);
    push_n(2, 'h400);
    send_cmd(AW'('h400), XW'(8));
    respond(1);
    exp_ws++; exp_dn++;
    repeat (2) tick();
    chk("s6 fresh n_done", n_done, exp_dn);

    // random commands, sizes, backpressure and done timing
    for (int k = 0; k < 24; k++) begin
      int beats, dly;
      logic [XW-1:0] sz;
      beats = int'($urandom_range(0, 7));
      dly   = int'($urandom_range(0, 12));
      sz    = XW'(beats * 4 + int'($urandom_range(0, 3)));
      stop  = 0;
      fork
        push_n(beats, 'h8000 + k * 16);
        begin
          send_cmd(AW'($urandom), sz);
          if (beats > 0) respond(dly); else tick();
          stop = 1;
        end
        while (!stop) begin wr_tready = 1'($urandom_range(0, 1)); tick(); end
      join
      if (beats > 0) exp_ws++;
      exp_dn++;
      repeat (2) tick();
    end
    chk("final n_wstart", n_wstart, exp_ws);
    chk("final n_done", n_done, exp_dn);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
